// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned shift-add multiplier sequencer.
// Drives the shared combinational ALU (add only) for WIDTH iterations and
// returns the 2*WIDTH product in {H,L}.
// Optional feature macro: MUL_ZERO_BYPASS_EN -- a request with a zero operand
// skips the RUN phase and goes straight to DONE with a zero product.
module alu_mul_seq #(
  parameter int            WIDTH      = 16,
  parameter logic [2:0]    ALU_OP_ADD = 3'b010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_cin,
  output logic                 alu_ainvert,
  output logic                 alu_bnegate,
  output logic                 alu_less,
  output logic [2:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration index of the last RUN edge.
  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;   // multiplicand
  logic [WIDTH-1:0] h_q, h_d;   // accumulator / high product
  logic [WIDTH-1:0] l_q, l_d;   // multiplier, shifted out as low product fills in
  logic [4:0]       cnt_q, cnt_d;

  // State and datapath registers; reset clears everything so the product
  // output reads zero and any partial product is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      h_q     <= h_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and ALU operand steering.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    h_d     = h_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    alu_a   = '0;
    alu_b   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = in_a;
          l_d     = in_b;
          h_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MUL_ZERO_BYPASS_EN
          // Zero operand: product is known to be zero, no ALU iterations.
          if ((in_a == '0) || (in_b == '0)) begin
            l_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        // Add the multiplicand only when the current multiplier LSB is set;
        // the carry becomes the new top bit as {H,L} shifts right.
        alu_a = h_q;
        alu_b = l_q[0] ? m_q : '0;
        {h_d, l_d} = {alu_cout, alu_result, l_q[WIDTH-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign out_product = {h_q, l_q};

  // The ALU is only ever used as a plain adder.
  assign alu_cin     = 1'b0;
  assign alu_ainvert = 1'b0;
  assign alu_bnegate = 1'b0;
  assign alu_less    = 1'b0;
  assign alu_op      = ALU_OP_ADD;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiplier sequencer for the 16-bit CPU. It accepts a multiply request, drives the shared 16-bit ripple ALU (a, b, cin, ainvert, bnegate, less, op → result, cout) through shift-add iterations, and returns a 32-bit product. It sits beside the execute stage and owns the ALU port while busy. The ALU itself is purely combinational, so the ALU add path is evaluated within the same cycle.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH.
- ALU_OP_ADD, 3'b010, ALU op code selecting add.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_a, in_b  in  WIDTH  multiplicand, multiplier (unsigned).
- out_valid  out  1  product valid (DONE state).
- out_ready  in  1  consumer accepts product.
- out_product  out  2*WIDTH  {H,L} product register.
- busy  out  1  high in RUN or DONE.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_cin, alu_ainvert, alu_bnegate, alu_less  out  1  always 0.
- alu_op  out  3  always ALU_OP_ADD.
- alu_result  in  WIDTH  ALU sum.
- alu_cout  in  1  ALU carry out (bit WIDTH-1).

## Operation
- Registers: M (multiplicand), H (accumulator), L (multiplier/low product), cnt (5 bits).
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid: M←in_a, L←in_b, H←0, cnt←0, then go to RUN.
- RUN: alu_a=H, alu_b = L[0] ? M : 0. At each edge: {H,L} ← {alu_cout, alu_result, L[WIDTH-1:1]}, cnt←cnt+1. After the edge where cnt==WIDTH-1, go to DONE.
- DONE: out_valid=1, out_product={H,L}, held stable. If out_ready, go to IDLE.
- Outside RUN: alu_a=0, alu_b=0.
- in_valid outside IDLE is ignored. Operands are not sampled.
- The result is modulo-free: an unsigned 16x16 product always fits in 32 bits.

## Timing
- Reset values: state=IDLE, H=L=M=0, cnt=0. Outputs: in_ready=1, out_valid=0, out_product=0, busy=0, all alu_* outputs 0 except alu_op=ALU_OP_ADD.
- Latency: request accepted at edge k. out_valid is high after edge k+WIDTH (16 cycles).
- Throughput: one product per WIDTH+2 cycles when out_ready is held high (accept edge, 16 RUN edges, DONE→IDLE edge).
- A new request cannot be accepted in the same cycle as the out handshake. in_ready rises the cycle after out_ready is sampled.
- Reset mid-RUN or mid-DONE: asynchronous return to IDLE with the reset values above. The partial product is discarded.
- out_ready low in DONE: the product is held indefinitely.

## Configuration
- MUL_ZERO_BYPASS_EN defined: in IDLE, if in_valid and (in_a==0 or in_b==0), load H=L=0 and go directly to DONE. out_valid is high after 1 edge, and the ALU is not used.
- MUL_ZERO_BYPASS_EN undefined: every request takes the full WIDTH RUN cycles, including zero operands.

## Test plan
- in_a=3, in_b=5 with out_ready=1 → out_valid asserts exactly 16 cycles after accept, out_product=0x0000000F, in_ready high the following cycle.
- in_a=0xFFFF, in_b=0xFFFF → out_product=0xFFFE0001. alu_cout=1 is observed during RUN and captured into H.
- in_a=0x1234, in_b=0x0100, out_ready held low for 5 cycles after out_valid → out_product=0x00123400 stays stable, state stays DONE, and in_valid pulses are ignored.
- rst_n driven low at RUN cycle 7 → in_ready=1, out_valid=0, out_product=0 immediately (asynchronously). A new request 7*9 then completes with 0x3F.
- With MUL_ZERO_BYPASS_EN: in_a=0, in_b=0xABCD → out_valid after 1 cycle, product 0. Without the macro: 16 cycles, product 0.
- Back-to-back: 2*3 then 0x8000*2 with out_ready=1 → 0x6 then 0x00010000. Spacing between accepts is 18 cycles.
